alu_exec_stage: RTL

//  Parametrised, registered execute stage: B-operand select (RF_B vs Immed), ALU op,

---
 rtl/alu_exec_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage: B-operand select, single-cycle ALU ops, iterative shift-add multiply.
// Latency: 1 cycle for ALU ops, WIDTH cycles for MUL (accept edge to Out_valid).
// Backpressure: single-entry output register; In_ready low while busy or while holding an unconsumed result.
// Optional: define ALU_OVF_EN to add the signed-overflow output Ovf for ADD/SUB.
module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] RF_A,
    input  logic [WIDTH-1:0] RF_B,
    input  logic [WIDTH-1:0] Immed,
    input  logic             ALU_Bin_sel,
    input  logic [3:0]       ALU_func,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Zero
`ifdef ALU_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_step;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             is_mul;
    logic             mul_done;
    logic             load_res;
`ifdef ALU_OVF_EN
    logic             alu_ovf;
    logic             load_ovf;
`endif

    assign is_mul   = (ALU_func == 4'b1110);
    assign In_ready = (state == S_IDLE) && (!Out_valid || Out_ready);
    assign accept   = In_valid && In_ready;
    assign mul_step = acc + (mul_b[0] ? mul_a : '0);
    assign mul_done = (state == S_MUL) && (cnt == CNT_LAST);
    // A MUL can only finish while In_ready is low, so the two load sources never collide.
    assign load_res = (accept && !is_mul) || mul_done;
    assign load_val = mul_done ? mul_step : alu_res;

    // Single-cycle ALU result from the live operands (B chosen by the select line).
    always_comb begin
        op_b    = ALU_Bin_sel ? Immed : RF_B;
        sum     = RF_A + op_b;
        diff    = RF_A - op_b;
        alu_res = '0;
        case (ALU_func)
            4'b0000: alu_res = sum;
            4'b0001: alu_res = diff;
            4'b0010: alu_res = RF_A & op_b;
            4'b0011: alu_res = RF_A | op_b;
            4'b0100: alu_res = ~RF_A;
            4'b0101: alu_res = ~(RF_A & op_b);
            4'b0110: alu_res = ~(RF_A | op_b);
            4'b1000: alu_res = $signed(RF_A) >>> 1;
            4'b1001: alu_res = RF_A >> 1;
            4'b1010: alu_res = RF_A << 1;
            4'b1100: alu_res = {RF_A[WIDTH-2:0], RF_A[WIDTH-1]};
            4'b1101: alu_res = {RF_A[0], RF_A[WIDTH-1:1]};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_OVF_EN
    // Signed overflow for ADD/SUB only; MUL results always report no overflow.
    always_comb begin
        alu_ovf = 1'b0;
        if (ALU_func == 4'b0000)
            alu_ovf = (RF_A[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != RF_A[WIDTH-1]);
        else if (ALU_func == 4'b0001)
            alu_ovf = (RF_A[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != RF_A[WIDTH-1]);
        load_ovf = mul_done ? 1'b0 : alu_ovf;
    end
`endif

    // FSM next state: leave IDLE only on an accepted MUL, return after the last iteration.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
            S_MUL:   if (cnt == CNT_LAST)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register; reset aborts any multiply in flight.
    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Shift-add multiplier: one multiplier bit consumed per cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept && is_mul) begin
            mul_a <= RF_A;
            mul_b <= op_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == S_MUL) begin
            acc   <= mul_step;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    // Output register: a new load wins over a drain so back-to-back results see no bubble.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out_valid <= 1'b0;
            ALU_out   <= '0;
            Zero      <= 1'b0;
`ifdef ALU_OVF_EN
            Ovf       <= 1'b0;
`endif
        end else if (load_res) begin
            Out_valid <= 1'b1;
            ALU_out   <= load_val;
            Zero      <= (load_val == '0);
`ifdef ALU_OVF_EN
            Ovf       <= load_ovf;
`endif
        end else if (Out_ready) begin
            Out_valid <= 1'b0;
        end
    end

endmodule
